// File: rtl/iddr_deser.sv
// DDR deserialiser: WIDTH data lanes plus a frame lane are captured on both clock
// edges and sliced into SER_FACTOR-bit words whose boundary is trained on the frame lane.
module iddr_deser #(
   parameter int                    WIDTH         = 4,
   parameter int                    SER_FACTOR    = 14,
   parameter logic [SER_FACTOR-1:0] FRAME_PATTERN = 14'h3F80,
   parameter int                    LOCK_COUNT    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WIDTH-1:0]            d,
   input  logic                        frame,
   input  logic                        align_req,
   output logic [WIDTH*SER_FACTOR-1:0] out_data,
   output logic                        out_valid,
   output logic                        locked,
   output logic                        align_fail,
   output logic [3:0]                  bit_offset,
   output logic [15:0]                 err_count,
   output logic [2:0]                  state_o
);
   localparam int S    = SER_FACTOR;
   localparam int NL   = WIDTH + 1;
   localparam int PH_W = $clog2(S / 2);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(S / 2 - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEARCH = 3'd1,
      SETTLE = 3'd2,
      LOCKED = 3'd3,
      FAIL   = 3'd4
   } state_t;

   // Lane WIDTH is the frame lane; it travels through exactly the same path as data.
   logic [NL-1:0]      lane_in;
   logic [NL-1:0]      q1_raw_q, q2_raw_q, q1_q, q2_q;
   logic [2*S-1:0]     hist_q [NL];
   logic [S-1:0]       word   [NL];
   logic [PH_W-1:0]    phase_q;
   logic               strobe;
   logic [WIDTH*S-1:0] out_data_q;
   logic [S-1:0]       frame_word_q;
   logic               out_valid_q;

   state_t      state_q, state_d;
   logic [3:0]  off_q, off_d;
   logic [7:0]  match_q, match_d;
   logic [4:0]  tries_q, tries_d;
   logic        settle_q, settle_d;
   logic [15:0] err_q, err_d;

   assign lane_in = {frame, d};
   assign strobe  = (phase_q == PH_LAST);

   always_ff @(negedge clk or posedge rst) begin
      if (rst) q2_raw_q <= '0;
      else     q2_raw_q <= lane_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1_raw_q <= '0;
         q1_q     <= '0;
         q2_q     <= '0;
         for (int l = 0; l < NL; l++) hist_q[l] <= '0;
      end else begin
         q1_raw_q <= lane_in;
         q1_q     <= q1_raw_q;
         q2_q     <= q2_raw_q;
         for (int l = 0; l < NL; l++)
            hist_q[l] <= {hist_q[l][2*S-3:0], q1_q[l], q2_q[l]};
      end
   end

   always_comb begin
      for (int l = 0; l < NL; l++) word[l] = hist_q[l][off_q +: S];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q      <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         frame_word_q <= '0;
      end else begin
         phase_q     <= strobe ? '0 : phase_q + PH_W'(1);
         out_valid_q <= strobe;
         if (strobe) begin
            for (int l = 0; l < WIDTH; l++) out_data_q[l*S +: S] <= word[l];
            frame_word_q <= word[WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         off_q    <= '0;
         match_q  <= '0;
         tries_q  <= '0;
         settle_q <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         off_q    <= off_d;
         match_q  <= match_d;
         tries_q  <= tries_d;
         settle_q <= settle_d;
         err_q    <= err_d;
      end
   end

   // The FSM judges the word registered on the previous strobe (out_valid_q high).
   always_comb begin
      state_d  = state_q;
      off_d    = off_q;
      match_d  = match_q;
      tries_d  = tries_q;
      settle_d = settle_q;
      err_d    = err_q;
      if (align_req) begin
         state_d = SEARCH;
         off_d   = '0;
         match_d = '0;
         tries_d = '0;
         err_d   = '0;
      end else if (out_valid_q) begin
         case (state_q)
            SEARCH: begin
               if (frame_word_q == FRAME_PATTERN) begin
                  match_d = match_q + 8'd1;
                  if (match_q == 8'(LOCK_COUNT - 1)) state_d = LOCKED;
               end else begin
                  match_d = '0;
                  tries_d = tries_q + 5'd1;
                  off_d   = (off_q == 4'(S - 1)) ? 4'd0 : off_q + 4'd1;
                  if (tries_q == 5'(S - 1)) begin
                     state_d = FAIL;
                  end else begin
                     state_d  = SETTLE;
                     settle_d = 1'b0;
                  end
               end
            end
            SETTLE: begin
               if (settle_q) state_d = SEARCH;
               else          settle_d = 1'b1;
            end
            LOCKED: begin
               if (frame_word_q != FRAME_PATTERN && err_q != 16'hFFFF) err_d = err_q + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign locked     = (state_q == LOCKED);
   assign align_fail = (state_q == FAIL);
   assign bit_offset = off_q;
   assign err_count  = err_q;
   assign state_o    = state_q;
endmodule

// File: doc/iddr_deser.md
IDDR_DESER -- requirements
Module: iddr_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of DDR serial data lanes.
REQ-002 SHALL have parameter SER_FACTOR, default 14: bits per deserialised word; even, 4..16.
REQ-003 SHALL have parameter FRAME_PATTERN, default 14'h3F80: expected frame-lane word, SER_FACTOR bits.
REQ-004 SHALL have parameter LOCK_COUNT, default 16: consecutive frame matches required for lock, 1..255.
REQ-005 SHALL have port clk  input  1  bit clock; data is captured on both edges, all state is posedge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port d  input  WIDTH  DDR serial data lanes.
REQ-008 SHALL have port frame  input  1  DDR frame lane, same timing as d.
REQ-009 SHALL have port align_req  input  1  one-cycle pulse that (re)starts alignment.
REQ-010 SHALL have port out_data  output  WIDTH*SER_FACTOR  lane n word at [n*SER_FACTOR +: SER_FACTOR], MSB first in time.
REQ-011 SHALL have port out_valid  output  1  one-cycle strobe marking a new out_data word.
REQ-012 SHALL have port locked  output  1  frame alignment achieved.
REQ-013 SHALL have port align_fail  output  1  all bit offsets tried without lock.
REQ-014 SHALL have port bit_offset  output  4  current word-boundary offset.
REQ-015 SHALL have port err_count  output  16  saturating count of frame mismatches while locked.

Function
REQ-016 SHALL capture each lane, frame included, generic-DDR style: posedge sample q1 and negedge sample q2, both re-registered on posedge; 2-cycle capture latency; q1 is earlier in time than q2.
REQ-017 SHALL shift each lane history hist (2*SER_FACTOR bits) every cycle: hist <= {hist[2S-3:0], q1, q2}.
REQ-018 SHALL extract word = hist[bit_offset+S-1 : bit_offset]; bit_offset 0 = newest S bits; incrementing bit_offset moves the boundary one bit earlier in time.
REQ-019 SHALL run a phase counter 0..S/2-1, free-running from reset; on wrap (phase==S/2-1), out_data and the internal frame word SHALL be registered and out_valid SHALL pulse for exactly one cycle.
REQ-020 SHALL make out_valid and out_data independent of lock state; words are always emitted.
REQ-021 SHALL implement FSM IDLE, SEARCH, SETTLE, LOCKED, FAIL; all evaluation happens only on word strobes.
REQ-022 IDLE: on align_req go to SEARCH with bit_offset=0, match_cnt=0, tries=0.
REQ-023 SEARCH, frame word == FRAME_PATTERN: match_cnt+1; on reaching LOCK_COUNT go to LOCKED and set locked=1.
REQ-024 SEARCH, mismatch: match_cnt=0, tries+1, bit_offset+1 wrapping S-1->0, go to SETTLE; if tries reaches S, go to FAIL instead and set align_fail=1.
REQ-025 SETTLE: discard 2 word strobes, then return to SEARCH.
REQ-026 LOCKED, mismatch: err_count+1, saturating at 16'hFFFF; locked stays 1 and bit_offset is unchanged.
REQ-027 FAIL: hold bit_offset at S-1 equivalent after wrap (value 0); await align_req.
REQ-028 align_req in any state SHALL restart as in REQ-022, clearing locked, align_fail, and err_count in the same cycle; align_req coincident with a word strobe takes priority over that strobe's evaluation.
REQ-029 SHALL not advance the FSM on cycles without a strobe; align_req outside IDLE or FAIL is legal.

Reset
REQ-030 rst SHALL asynchronously clear: hist, IDDR registers, phase counter, out_data=0, out_valid=0, locked=0, align_fail=0, bit_offset=0, err_count=0, and FSM=IDLE.
REQ-031 Reset mid-alignment SHALL abandon the search; after release the block waits in IDLE for align_req.
REQ-032 The first out_valid after reset release SHALL occur on the S/2-th posedge.

Verification
REQ-033 Frame lane driven with 0x3F80 at offset 0, align_req -> locked=1 after 16 strobes, bit_offset=0, align_fail=0.
REQ-034 Frame lane skewed by 5 bits -> 5 slips, each followed by 2 discarded strobes, then lock with bit_offset=5; lane data 0x1ABC is recovered as 0x1ABC.
REQ-035 Frame lane held constant at 0 -> after 14 mismatches align_fail=1, locked=0, and out_valid continues every 7 cycles.
REQ-036 While locked, 3 corrupted frame words -> err_count=3 and locked stays 1; align_req -> err_count=0, locked=0, and the FSM enters SEARCH.
REQ-037 rst asserted mid-SEARCH -> all outputs 0 immediately; after release, no lock without align_req.
REQ-038 WIDTH=1, SER_FACTOR=4, FRAME_PATTERN=4'hC, LOCK_COUNT=1 -> lock on the first matching strobe and out_valid every 2 cycles.
